div_arbiter: RTL and testbench

- Shares one iterative `div` unit between NUM_REQ requesters (executer instances or harts) with round-robin arbitration.
- Accepts one division per grant and drives the divider's kick/ready handshake.
- Returns quotient or remainder to the granted requester only.
- Sits between the executers' div request paths and a single `div` instance.

---
 rtl/div_arbiter_pkg.sv | 19 +
 rtl/div_arbiter_rr_pick.sv | 34 +++
 rtl/div_arbiter.sv | 120 ++++++++++++
 tb/tb_div_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/div_arbiter_pkg.sv
// Shared definitions for the divider arbiter: div op encodings and arbiter FSM states.
package div_arbiter_pkg;

  localparam logic [3:0] DIV_NOP = 4'h0;
  localparam logic [3:0] DIV_DIV = 4'h1;
  localparam logic [3:0] DIV_REM = 4'h2;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_KICK,
    ARB_WAIT,
    ARB_RESP
  } arb_state_e;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == DIV_DIV) || (op == DIV_REM);
  endfunction

endpackage

// File: rtl/div_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module div_arbiter_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [IW:0]   s;
  logic [IW-1:0] j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    s     = '0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      s = {1'b0, ptr} + (IW+1)'(k);
      if (s >= (IW+1)'(N)) s = s - (IW+1)'(N);
      j = s[IW-1:0];
      if (!found && req[j]) begin
        found  = 1'b1;
        idx    = j;
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one iterative divider among NUM_REQ requesters.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int W       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*4-1:0] req_op,
  input  logic [NUM_REQ-1:0]   req_unsigned,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  input  logic [NUM_REQ-1:0]   req_cancel,
  output logic [NUM_REQ-1:0]   req_grant,
  output logic [NUM_REQ-1:0]   resp_valid,
  output logic [W-1:0]         resp_result,
  output logic                 resp_unknown_op,
  output logic                 busy,
  output logic                 div_kick,
  output logic                 div_unsigned_flag,
  output logic [W-1:0]         div_dividend,
  output logic [W-1:0]         div_divider,
  input  logic                 div_ready,
  input  logic [W-1:0]         div_quotient,
  input  logic [W-1:0]         div_remainder
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         state, state_nxt;
  logic [IW-1:0]      rr_ptr, owner, pick_idx;
  logic [NUM_REQ-1:0] pick_req, pick_gnt;
  logic               pick_found;
  logic [3:0]         op, pick_op;
  logic               unk, cancelled, owner_cancel;
  logic [W-1:0]       result;

  // A request cancelled in the same cycle it is presented is never granted.
  assign pick_req     = req_valid & ~req_cancel;
  assign pick_op      = req_op[pick_idx*4 +: 4];
  assign owner_cancel = req_cancel[owner];
  assign resp_result  = result;

  div_arbiter_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (pick_req),
    .ptr   (rr_ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (pick_found) state_nxt = is_div_op(pick_op) ? ARB_KICK : ARB_RESP;
      ARB_KICK: state_nxt = ARB_WAIT;
      ARB_WAIT: if (div_ready) state_nxt = ARB_RESP;
      ARB_RESP: state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    req_grant       = '0;
    resp_valid      = '0;
    resp_unknown_op = 1'b0;
    div_kick        = 1'b0;
    busy            = (state != ARB_IDLE);
    case (state)
      ARB_IDLE: if (!reset) req_grant = pick_gnt;
      ARB_KICK: div_kick = 1'b1;
      ARB_RESP: if (!cancelled && !owner_cancel) begin
        resp_valid[owner] = 1'b1;
        resp_unknown_op   = unk;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr            <= '0;
      owner             <= '0;
      op                <= DIV_NOP;
      unk               <= 1'b0;
      cancelled         <= 1'b0;
      div_unsigned_flag <= 1'b0;
      div_dividend      <= '0;
      div_divider       <= '0;
      result            <= '0;
    end else begin
      if (state == ARB_IDLE) begin
        cancelled <= 1'b0;
        if (pick_found) begin
          owner             <= pick_idx;
          op                <= pick_op;
          unk               <= !is_div_op(pick_op);
          div_unsigned_flag <= req_unsigned[pick_idx];
          div_dividend      <= req_a[pick_idx*W +: W];
          div_divider       <= req_b[pick_idx*W +: W];
          rr_ptr            <= (pick_idx == IW'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
          result            <= '0;
        end
      end else if (owner_cancel) begin
        cancelled <= 1'b1;
      end
      // The KICK cycle is skipped here so a stale ready from the previous op is ignored.
      if (state == ARB_WAIT && div_ready)
        result <= (op == DIV_DIV) ? div_quotient : div_remainder;
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter; the bench plays the divider with hand-computed results.
module tb_div_arbiter;
  import div_arbiter_pkg::*;

  localparam int N = 2;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_unsigned, req_cancel;
  logic [N*4-1:0] req_op;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_grant, resp_valid;
  logic [W-1:0]   resp_result, div_dividend, div_divider, div_quotient, div_remainder;
  logic           resp_unknown_op, busy, div_kick, div_unsigned_flag, div_ready;

  int vectors = 0;
  int errors  = 0;

  div_arbiter #(.NUM_REQ(N), .W(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_unsigned(req_unsigned),
    .req_a(req_a), .req_b(req_b), .req_cancel(req_cancel),
    .req_grant(req_grant), .resp_valid(resp_valid), .resp_result(resp_result),
    .resp_unknown_op(resp_unknown_op), .busy(busy),
    .div_kick(div_kick), .div_unsigned_flag(div_unsigned_flag),
    .div_dividend(div_dividend), .div_divider(div_divider),
    .div_ready(div_ready), .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int who, input logic [3:0] op, input logic uns,
                         input logic [31:0] a, input logic [31:0] b);
    req_op[who*4 +: 4]  = op;
    req_unsigned[who]   = uns;
    req_a[who*W +: W]   = a;
    req_b[who*W +: W]   = b;
  endtask

  // One uncontended op: grant, kick, one WAIT cycle with ready, response, back to idle.
  task automatic do_op(input int who, input logic [3:0] op, input logic uns,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] r, input logic [31:0] exp);
    set_req(who, op, uns, a, b);
    req_valid[who] = 1'b1;
    #1;
    chk("grant", 32'(req_grant), 32'(1 << who));
    tick();
    req_valid[who] = 1'b0;
    #1;
    chk("kick", 32'(div_kick), 1);
    chk("dividend", div_dividend, a);
    chk("divider", div_divider, b);
    chk("unsigned_flag", 32'(div_unsigned_flag), 32'(uns));
    chk("grant_off", 32'(req_grant), 0);
    tick();
    chk("kick_off", 32'(div_kick), 0);
    chk("wait_no_resp", 32'(resp_valid), 0);
    div_ready = 1'b1; div_quotient = q; div_remainder = r;
    tick();
    div_ready = 1'b0;
    chk("resp_valid", 32'(resp_valid), 32'(1 << who));
    chk("resp_result", resp_result, exp);
    chk("resp_unknown", 32'(resp_unknown_op), 0);
    tick();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_resp_off", 32'(resp_valid), 0);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0; req_unsigned = '0; req_cancel = '0;
    req_op = '0; req_a = '0; req_b = '0;
    div_ready = 1'b0; div_quotient = '0; div_remainder = '0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(req_grant), 0);
    chk("rst_resp", 32'(resp_valid), 0);
    chk("rst_kick", 32'(div_kick), 0);
    chk("rst_dividend", div_dividend, 0);
    chk("rst_result", resp_result, 0);
    reset = 1'b0;
    tick();

    // Single ops: 100/7 signed, -7 rem 2 signed, 0xFFFFFFF9 rem 2 unsigned.
    do_op(0, DIV_DIV, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 32'd14);
    do_op(0, DIV_REM, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(0, DIV_REM, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 32'd1);

    // Unknown op on req1: response next cycle, result 0, no kick.
    set_req(1, 4'hF, 1'b0, 32'd5, 32'd5);
    req_valid = 2'b10;
    #1;
    chk("unk_grant", 32'(req_grant), 32'b10);
    tick();
    req_valid = 2'b00;
    chk("unk_resp_valid", 32'(resp_valid), 32'b10);
    chk("unk_flag", 32'(resp_unknown_op), 1);
    chk("unk_result", resp_result, 0);
    chk("unk_kick", 32'(div_kick), 0);
    tick();
    chk("unk_idle", 32'(busy), 0);
    chk("unk_flag_off", 32'(resp_unknown_op), 0);

    // Contention: both held, grants alternate 0,1,0,1. req0: 20/3 -> 6, req1: 23 rem 5 -> 3.
    set_req(0, DIV_DIV, 1'b0, 32'd20, 32'd3);
    set_req(1, DIV_REM, 1'b0, 32'd23, 32'd5);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_grant", 32'(req_grant), (i % 2 == 0) ? 32'b01 : 32'b10);
      tick();
      chk("rr_kick", 32'(div_kick), 1);
      tick();
      div_ready = 1'b1;
      div_quotient  = (i % 2 == 0) ? 32'd6 : 32'd4;
      div_remainder = (i % 2 == 0) ? 32'd2 : 32'd3;
      tick();
      div_ready = 1'b0;
      if (i == 3) req_valid = 2'b00;
      chk("rr_resp_valid", 32'(resp_valid), (i % 2 == 0) ? 32'b01 : 32'b10);
      chk("rr_result", resp_result, (i % 2 == 0) ? 32'd6 : 32'd3);
      tick();
    end
    chk("rr_idle", 32'(busy), 0);

    // Cancel req0 three cycles after kick; req1 (81/9) pending; ready left high (stale) into req1's KICK.
    set_req(0, DIV_DIV, 1'b0, 32'd50, 32'd5);
    set_req(1, DIV_DIV, 1'b0, 32'd81, 32'd9);
    req_valid = 2'b11;
    #1;
    chk("cx_grant0", 32'(req_grant), 32'b01);
    tick();
    req_valid = 2'b10;
    chk("cx_kick", 32'(div_kick), 1);
    tick(); tick(); tick();
    req_cancel = 2'b01;
    tick();
    req_cancel = 2'b00;
    chk("cx_busy", 32'(busy), 1);
    div_ready = 1'b1; div_quotient = 32'd10; div_remainder = 32'd0;
    tick();
    chk("cx_no_resp", 32'(resp_valid), 0);
    chk("cx_resp_busy", 32'(busy), 1);
    tick();
    #1;
    chk("cx_grant1", 32'(req_grant), 32'b10);
    tick();
    req_valid = 2'b00;
    chk("stale_kick", 32'(div_kick), 1);
    chk("stale_dividend", div_dividend, 32'd81);
    tick();
    div_ready = 1'b0;
    chk("stale_ignored", 32'(resp_valid), 0);
    chk("stale_busy", 32'(busy), 1);
    tick();
    div_ready = 1'b1; div_quotient = 32'd9; div_remainder = 32'd0;
    tick();
    div_ready = 1'b0;
    chk("stale_resp_valid", 32'(resp_valid), 32'b10);
    chk("stale_result", resp_result, 32'd9);
    tick();
    chk("stale_idle", 32'(busy), 0);

    // Cancel together with valid in IDLE: no grant.
    req_valid = 2'b01; req_cancel = 2'b01;
    #1;
    chk("cx_idle_grant", 32'(req_grant), 0);
    tick();
    req_valid = 2'b00; req_cancel = 2'b00;
    chk("cx_idle_busy", 32'(busy), 0);

    // Reset during WAIT abandons the op; a later op completes normally.
    set_req(0, DIV_DIV, 1'b1, 32'd9, 32'd3);
    req_valid = 2'b01;
    #1;
    chk("rw_grant", 32'(req_grant), 32'b01);
    tick();
    req_valid = 2'b00;
    tick();
    reset = 1'b1; div_ready = 1'b1; div_quotient = 32'd3;
    tick();
    chk("rw_busy", 32'(busy), 0);
    chk("rw_kick", 32'(div_kick), 0);
    chk("rw_resp", 32'(resp_valid), 0);
    chk("rw_dividend", div_dividend, 0);
    chk("rw_divider", div_divider, 0);
    chk("rw_unsigned", 32'(div_unsigned_flag), 0);
    chk("rw_result", resp_result, 0);
    reset = 1'b0; div_ready = 1'b0;
    tick();
    chk("rw_after_resp", 32'(resp_valid), 0);
    chk("rw_after_busy", 32'(busy), 0);
    do_op(0, DIV_DIV, 1'b1, 32'd9, 32'd3, 32'd3, 32'd0, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
